// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// timeout-counter sizing helper.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

    // A zero limit disables the timer; still give the counter one bit so it is never zero-width.
    function automatic int unsigned wait_cnt_width(input int unsigned limit);
        if (limit == 0) return 1;
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter: cleared before ACCESS, counts ACCESS edges with
// pready low, and flags the edge on which the count would reach the limit.
module apb_wait_timer #(
    parameter int CNT_W = 1
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_count_inc;

    assign w_count_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};

    // Combinational so the FSM can abort on the very edge the limit is reached.
    assign o_expired = i_enable && (i_limit != '0) && (w_count_inc >= {1'b0, i_limit});

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= w_count_inc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/apb_requester.sv
// APB requester: takes one command at a time, runs SETUP->ACCESS toward a single
// completer, and returns a one-cycle response with optional wait-state timeout.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel_x,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    localparam int               CNT_W = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    apb_state_t        r_state;
    apb_state_t        w_state_next;

    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    logic              w_accept;
    logic              w_done;
    logic              w_wait;
    logic              w_expired;
    logic              w_abort;

    assign cmd_ready = (r_state == APB_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_done    = (r_state == APB_ACCESS) && pready;
    assign w_wait    = (r_state == APB_ACCESS) && !pready;
    assign w_abort   = w_wait && w_expired;

    apb_wait_timer #(
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .i_clear   (r_state == APB_SETUP),
        .i_enable  (w_wait),
        .i_limit   (LIMIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state <= APB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next-state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            APB_IDLE:   if (cmd_valid)         w_state_next = APB_SETUP;
            APB_SETUP:                         w_state_next = APB_ACCESS;
            APB_ACCESS: if (pready || w_expired) w_state_next = APB_IDLE;
            default:                           w_state_next = APB_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;

            if (w_accept) begin
                r_psel   <= 1'b1;
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                if (cmd_write) r_pwdata <= cmd_wdata;
            end

            if (r_state == APB_SETUP) begin
                r_penable <= 1'b1;
            end

            // pready is tested first so a completion on the limit edge is not a timeout.
            if (w_done) begin
                r_psel        <= 1'b0;
                r_penable     <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                r_rsp_err     <= pslverr;
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_psel        <= 1'b0;
                r_penable     <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign psel_x      = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: a planned completer model supplies wait states,
// expected responses are queued at issue time and checked by an independent monitor.
module tb_apb_requester;
    import apb_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 4;

    logic              pclk = 1'b0;
    logic              preset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              psel_x;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready = 1'b0;
    logic [DATA_W-1:0] prdata = '0;
    logic              pslverr = 1'b0;

    apb_requester #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel_x      (psel_x),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] pwdata;
        logic [7:0] rdata;
        logic       err;
        logic       to;
        int         n_access;
        int         lat;
        int         accept_cyc;
    } exp_t;

    typedef struct {
        int         waits;
        logic [7:0] rdata;
        logic       err;
    } plan_t;

    exp_t       sb_q[$];
    plan_t      plan_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] last_wdata = '0;

    always @(posedge pclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Completer: holds pready low for 'waits' ACCESS cycles, then completes with planned data.
    initial begin
        plan_t cur;
        int    k;
        cur = '{waits: 1000, rdata: 8'h00, err: 1'b0};
        k = 0;
        forever begin
            @(negedge pclk);
            if (!preset_n) begin
                pready = 1'b0;
                k = 0;
            end else if (psel_x && !penable) begin
                if (plan_q.size() > 0) cur = plan_q.pop_front();
                else cur = '{waits: 1000, rdata: 8'h00, err: 1'b0};
                k = 0;
                pready  = 1'b0;
                prdata  = 8'($urandom);
                pslverr = 1'($urandom);
            end else if (psel_x && penable) begin
                k++;
                if (k > cur.waits) begin
                    pready  = 1'b1;
                    prdata  = cur.rdata;
                    pslverr = cur.err;
                end else begin
                    pready  = 1'b0;
                    prdata  = 8'($urandom);
                    pslverr = 1'($urandom);
                end
            end else begin
                pready  = 1'($urandom);
                prdata  = 8'($urandom);
                pslverr = 1'($urandom);
            end
        end
    end

    // Monitor: checks bus contents during a transfer and pops the scoreboard on each response.
    initial begin
        int   psel_n;
        int   pen_n;
        exp_t e;
        psel_n = 0;
        pen_n  = 0;
        forever begin
            @(negedge pclk);
            if (!preset_n) begin
                psel_n = 0;
                pen_n  = 0;
            end else begin
                if (psel_x) begin
                    psel_n++;
                    if (penable) pen_n++;
                    if (sb_q.size() == 0) begin
                        fail("bus_active_without_cmd");
                    end else begin
                        check("paddr",  paddr,  sb_q[0].addr);
                        check("pwrite", pwrite, sb_q[0].write);
                        check("pwdata", pwdata, sb_q[0].pwdata);
                    end
                end
                if (rsp_valid) begin
                    if (sb_q.size() == 0) begin
                        fail("unexpected_rsp");
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_rdata",     rsp_rdata,          e.rdata);
                        check("rsp_err",       rsp_err,            e.err);
                        check("rsp_timeout",   rsp_timeout,        e.to);
                        check("rsp_latency",   cyc - e.accept_cyc, e.lat);
                        check("psel_cycles",   psel_n,             e.n_access + 1);
                        check("penable_cycles", pen_n,             e.n_access);
                        check("psel_in_rsp",   {psel_x, penable},  2'b00);
                    end
                    psel_n = 0;
                    pen_n  = 0;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input int waits, input logic [7:0] rdata, input logic err,
                         input logic hold, input logic b2b);
        exp_t  e;
        plan_t p;
        int    guard;
        guard = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!cmd_ready && guard < 100) begin
            @(negedge pclk);
            guard++;
        end
        if (!cmd_ready) begin
            fail("cmd_ready_wait");
            cmd_valid = 1'b0;
            return;
        end
        if (b2b) check("b2b_accept_in_rsp_cycle", rsp_valid, 1'b1);
        e.to       = (TIMEOUT > 0) && (waits >= TIMEOUT);
        e.n_access = e.to ? TIMEOUT : waits + 1;
        e.lat      = 1 + e.n_access;
        e.write    = wr;
        e.addr     = addr;
        if (wr) last_wdata = wdata;
        e.pwdata   = last_wdata;
        e.rdata    = (e.to || wr) ? 8'h00 : rdata;
        e.err      = e.to || err;
        e.accept_cyc = cyc + 1;
        p = '{waits: waits, rdata: rdata, err: err};
        sb_q.push_back(e);
        plan_q.push_back(p);
        @(negedge pclk);
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = 8'($urandom);
            cmd_wdata = 8'($urandom);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 200) begin
            @(negedge pclk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            fail("drain_timeout");
            sb_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic prev_hold;
        logic hold;
        #3;
        check("reset_cmd_ready",   cmd_ready,   1'b1);
        check("reset_psel",        psel_x,      1'b0);
        check("reset_penable",     penable,     1'b0);
        check("reset_pwrite",      pwrite,      1'b0);
        check("reset_paddr",       paddr,       8'h00);
        check("reset_pwdata",      pwdata,      8'h00);
        check("reset_rsp_valid",   rsp_valid,   1'b0);
        check("reset_rsp_rdata",   rsp_rdata,   8'h00);
        check("reset_rsp_err",     rsp_err,     1'b0);
        check("reset_rsp_timeout", rsp_timeout, 1'b0);
        @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);

        // Zero-wait read, two-wait write, slave error.
        issue(1'b0, 8'h01, 8'h00, 0, 8'hA5, 1'b0, 1'b0, 1'b0); drain();
        issue(1'b1, 8'h02, 8'h3C, 2, 8'h77, 1'b0, 1'b0, 1'b0); drain();
        issue(1'b0, 8'h03, 8'h00, 1, 8'h5A, 1'b1, 1'b0, 1'b0); drain();

        // Hung completer, pready on the limit edge, and a timed-out write.
        issue(1'b0, 8'h20, 8'h00, 50, 8'hEE, 1'b0, 1'b0, 1'b0); drain();
        issue(1'b0, 8'h21, 8'h00, TIMEOUT - 1, 8'hC3, 1'b0, 1'b0, 1'b0); drain();
        issue(1'b1, 8'h22, 8'h96, TIMEOUT, 8'h11, 1'b1, 1'b0, 1'b0); drain();

        // Three back-to-back reads with cmd_valid held.
        issue(1'b0, 8'h30, 8'h00, 0, 8'h11, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 8'h31, 8'h00, 0, 8'h22, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 8'h32, 8'h00, 0, 8'h33, 1'b0, 1'b0, 1'b1);
        drain();

        // Asynchronous reset while in ACCESS.
        issue(1'b0, 8'h40, 8'h00, 20, 8'h44, 1'b0, 1'b0, 1'b0);
        @(negedge pclk);
        check("pre_reset_access", {psel_x, penable}, 2'b11);
        #2 preset_n = 1'b0;
        #1;
        check("midreset_psel",      psel_x,    1'b0);
        check("midreset_penable",   penable,   1'b0);
        check("midreset_rsp_valid", rsp_valid, 1'b0);
        check("midreset_cmd_ready", cmd_ready, 1'b1);
        check("midreset_pwdata",    pwdata,    8'h00);
        sb_q.delete();
        plan_q.delete();
        last_wdata = 8'h00;
        repeat (2) @(negedge pclk);
        #2 preset_n = 1'b1;
        repeat (8) @(negedge pclk);
        check("post_reset_cmd_ready", cmd_ready, 1'b1);

        // Randomised traffic, occasionally back-to-back.
        prev_hold = 1'b0;
        for (int i = 0; i < 80; i++) begin
            hold = (i != 79) && ($urandom_range(0, 3) == 0);
            issue(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)),
                  8'($urandom), 1'($urandom), hold, prev_hold);
            prev_hold = hold;
        end
        drain();
        repeat (4) @(negedge pclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
